// File: rtl/spi_slave.sv
// SPI mode 0-3 byte slave with Wishbone register access.
// SPI inputs are oversampled in the clk_i domain; data and control/status registers are at adr[2]=0/1.
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  output logic        stall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  logic [0:0] state;
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic [7:0] conf, tx_buf, tx_shift, rx_shift, rx_byte;
  logic       tx_full, rx_unread, overrun, byte_done;
  logic [2:0] bit_cnt;

  logic       sclk_s, cs_s, mosi_s, cpol, cpha, selected;
  logic       cs_fall, cs_rise, sclk_edge, lead, trail;
  logic       sample_edge, shift_edge, boundary;
  logic [7:0] rx_next, reload_val;
  logic       bus_req, wr_data, rd_data, wr_ctrl, rd_ctrl;
  logic       unused_ok;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[1];
    cs_s        = cs_sync[1];
    mosi_s      = mosi_sync[1];
    cpol        = conf[1];
    cpha        = conf[0];
    selected    = ~cs_s;
    cs_fall     = cs_prev & ~cs_s;
    cs_rise     = ~cs_prev & cs_s;
    sclk_edge   = sclk_prev ^ sclk_s;
    lead        = selected & ~cs_fall & sclk_edge & (sclk_s != cpol);
    trail       = selected & ~cs_fall & sclk_edge & (sclk_s == cpol);
    sample_edge = cpha ? trail : lead;
    // cpha=1: the first leading edge of a byte must not shift, bit 7 is already on miso
    shift_edge  = cpha ? (lead & (bit_cnt != 3'd0)) : trail;
    boundary    = cpha ? (sample_edge & (bit_cnt == 3'd7)) : (trail & byte_done);
    rx_next     = {rx_shift[6:0], mosi_s};
    reload_val  = tx_full ? tx_buf : IDLE_BYTE;
    bus_req     = (state == S_IDLE) & cyc & stb;
    wr_data     = bus_req & we & ~adr[2];
    rd_data     = bus_req & ~we & ~adr[2];
    wr_ctrl     = bus_req & we & adr[2];
    rd_ctrl     = bus_req & ~we & adr[2];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      conf      <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      rx_byte   <= '0;
      rx_unread <= 1'b0;
      overrun   <= 1'b0;
      dat_o     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= IDLE_BYTE;
    end else begin
      case (state)
        S_IDLE:  if (cyc && stb) state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      // Bus clears first, SPI sets after, data write last: later assignments win on collisions
      if (rd_data) begin
        dat_o     <= {24'h0, rx_byte};
        rx_unread <= 1'b0;
      end
      if (rd_ctrl)
        dat_o <= {8'h0, conf, 11'h0, selected, overrun, tx_full, 1'b0, rx_unread};
      if (wr_ctrl && sel[2])
        conf <= dat_i[23:16];
      if (wr_ctrl && sel[0] && dat_i[3])
        overrun <= 1'b0;

      if (cs_fall) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        rx_shift  <= '0;
        tx_shift  <= reload_val;
        tx_full   <= 1'b0;
      end else if (cs_rise) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 3'd1;
          if (!cpha && bit_cnt == 3'd7)
            byte_done <= 1'b1;
        end
        if (boundary) begin
          rx_byte   <= cpha ? rx_next : rx_shift;
          rx_unread <= 1'b1;
          if (rx_unread)
            overrun <= 1'b1;
          tx_shift  <= reload_val;
          tx_full   <= 1'b0;
          bit_cnt   <= '0;
          byte_done <= 1'b0;
        end else if (shift_edge) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end

      if (wr_data) begin
        tx_buf  <= dat_i[7:0];
        tx_full <= 1'b1;
      end
    end
  end

  assign miso      = tx_shift[7];
  assign miso_oe   = selected;
  assign irq       = rx_unread | overrun;
  assign ack       = (state == S_DONE);
  assign stall     = 1'b0;
  assign unused_ok = &{1'b0, adr[3], adr[1:0], sel[3], sel[1], dat_i[31:24], dat_i[15:8]};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, Wishbone driver and a transaction-level register model.
module tb_spi_slave;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, irq, ack, stall;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0, sel = '0;
  logic [31:0] dat_i = '0, dat_o;

  int checks = 0;
  int failures = 0;
  localparam int H = 8;

  spi_slave #(.IDLE_BYTE(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .irq(irq),
    .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .stall(stall)
  );

  always #5 clk_i = ~clk_i;

  // Register model: what software and the master should observe
  logic [7:0] m_conf = '0, m_tx_buf = '0, m_rx_byte = '0, m_next_out = 8'hFF;
  logic       m_tx_full = 1'b0, m_rx_unread = 1'b0, m_overrun = 1'b0;

  function automatic void m_reload();
    m_next_out = m_tx_full ? m_tx_buf : 8'hFF;
    m_tx_full  = 1'b0;
  endfunction

  function automatic void m_byte_done(input logic [7:0] rx);
    if (m_rx_unread) m_overrun = 1'b1;
    m_rx_unread = 1'b1;
    m_rx_byte   = rx;
    m_reload();
  endfunction

  function automatic logic [31:0] m_status(input logic active);
    return {8'h0, m_conf, 11'h0, active, m_overrun, m_tx_full, 1'b0, m_rx_unread};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (ack) begin got = 1'b1; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wb_ack_timeout got ack=%b required 1", ack);
    end
  endtask

  task automatic wb_write(input logic adr2, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {1'b0, adr2, 2'b00}; sel = s; dat_i = d;
    wait_ack();
  endtask

  task automatic wb_read(input logic adr2, output logic [31:0] d);
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {1'b0, adr2, 2'b00}; sel = 4'hF;
    wait_ack();
    d = dat_o;
  endtask

  task automatic write_tx(input logic [7:0] v);
    wb_write(1'b0, 4'h1, {24'h0, v});
    m_tx_buf = v; m_tx_full = 1'b1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    m_conf = {6'b0, m};
    wb_write(1'b1, 4'b0100, {8'h0, m_conf, 16'h0});
    sclk = m_conf[1];
    tick(4);
  endtask

  task automatic cs_assert();
    @(negedge clk_i); cs_n = 1'b0;
    m_reload();
    tick(H);
  endtask

  task automatic cs_release();
    @(negedge clk_i); cs_n = 1'b1;
    tick(H);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    logic cpol, cpha;
    cpol = m_conf[1]; cpha = m_conf[0]; r = '0;
    for (int k = 0; k < n; k++) begin
      if (!cpha) begin
        mosi = b[7-k]; tick(H);
        sclk = ~cpol; r[7-k] = miso; tick(H);
        sclk = cpol;
      end else begin
        tick(H);
        sclk = ~cpol; mosi = b[7-k]; tick(H);
        sclk = cpol; r[7-k] = miso;
      end
    end
    tick(H);
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] r, output logic [7:0] exp);
    exp = m_next_out;
    spi_bits(b, 8, r);
    m_byte_done(b);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tick(3);
    checks++; if (miso !== 1'b1)    begin failures++; $display("FAIL reset_miso got %b required 1", miso); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe got %b required 0", miso_oe); end
    checks++; if (irq !== 1'b0)     begin failures++; $display("FAIL reset_irq got %b required 0", irq); end
    checks++; if (ack !== 1'b0)     begin failures++; $display("FAIL reset_ack got %b required 0", ack); end
    checks++; if (stall !== 1'b0)   begin failures++; $display("FAIL reset_stall got %b required 0", stall); end
    checks++; if (dat_o !== 32'h0)  begin failures++; $display("FAIL reset_dat_o got %h required 0", dat_o); end
    @(negedge clk_i); rst_i = 1'b1;
    tick(4);
    wb_read(1'b1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got %h required 0", d); end
    wb_read(1'b0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_data got %h required 0", d); end
  endtask

  task automatic test_mode0();
    logic [7:0] r, e;
    logic [31:0] d;
    set_mode(2'd0);
    write_tx(8'hA5);
    cs_assert();
    xfer(8'h3C, r, e);
    cs_release();
    checks++; if (r !== 8'hA5) begin failures++; $display("FAIL mode0_miso got %h required a5", r); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mode0_irq got %b required 1", irq); end
    wb_read(1'b1, d);
    checks++; if (d !== m_status(1'b0)) begin failures++; $display("FAIL mode0_status got %h required %h", d, m_status(1'b0)); end
    wb_read(1'b0, d); m_rx_unread = 1'b0;
    checks++; if (d !== 32'h3C) begin failures++; $display("FAIL mode0_rx got %h required 3c", d); end
    wb_read(1'b1, d);
    checks++; if (d[0] !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL mode0_unread_clear got %b/%b required 0/0", d[0], irq); end
  endtask

  task automatic test_modes();
    logic [7:0] r, e;
    logic [31:0] d;
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1:0]);
      write_tx(8'h5A);
      cs_assert();
      xfer(8'hC3, r, e);
      cs_release();
      checks++; if (r !== 8'h5A) begin failures++; $display("FAIL mode%0d_miso got %h required 5a", m, r); end
      wb_read(1'b0, d); m_rx_unread = 1'b0;
      checks++; if (d !== 32'hC3) begin failures++; $display("FAIL mode%0d_rx got %h required c3", m, d); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] r1, r2, e;
    logic [31:0] d;
    set_mode(2'd0);
    cs_assert();
    xfer(8'h01, r1, e);
    xfer(8'h02, r2, e);
    cs_release();
    checks++; if (r1 !== 8'hFF || r2 !== 8'hFF) begin failures++; $display("FAIL ovr_miso got %h %h required ff ff", r1, r2); end
    wb_read(1'b1, d);
    checks++; if (d !== m_status(1'b0) || d[3] !== 1'b1) begin failures++; $display("FAIL ovr_status got %h required %h", d, m_status(1'b0)); end
    wb_read(1'b0, d); m_rx_unread = 1'b0;
    checks++; if (d !== 32'h02) begin failures++; $display("FAIL ovr_rx got %h required 02", d); end
    wb_write(1'b1, 4'b0001, 32'h8); m_overrun = 1'b0;
    wb_read(1'b1, d);
    checks++; if (d !== m_status(1'b0) || irq !== 1'b0) begin failures++; $display("FAIL ovr_clear got %h irq %b required %h irq 0", d, irq, m_status(1'b0)); end
  endtask

  task automatic test_partial();
    logic [7:0] r, e;
    logic [31:0] d;
    cs_assert();
    spi_bits(8'($urandom), 4, r);
    cs_release();
    cs_assert();
    xfer(8'h77, r, e);
    cs_release();
    checks++; if (r !== e) begin failures++; $display("FAIL partial_miso got %h required %h", r, e); end
    wb_read(1'b1, d);
    checks++; if (d !== m_status(1'b0) || d[3] !== 1'b0) begin failures++; $display("FAIL partial_status got %h required %h", d, m_status(1'b0)); end
    wb_read(1'b0, d); m_rx_unread = 1'b0;
    checks++; if (d !== 32'h77) begin failures++; $display("FAIL partial_rx got %h required 77", d); end
  endtask

  task automatic test_coincident_write();
    logic [7:0] v, r1, r2, e1, e2;
    logic [31:0] d;
    v = 8'($urandom_range(0, 254));
    @(negedge clk_i); cs_n = 1'b0;
    // two synchronizer stages, then the edge detector fires: the write lands on the reload cycle
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h0; sel = 4'h1; dat_i = {24'h0, v};
    wait_ack();
    m_reload(); m_tx_buf = v; m_tx_full = 1'b1;
    tick(H);
    wb_read(1'b1, d);
    checks++; if (d[2] !== 1'b1 || d !== m_status(1'b1)) begin failures++; $display("FAIL coinc_status got %h required %h", d, m_status(1'b1)); end
    xfer(8'($urandom), r1, e1);
    xfer(8'($urandom), r2, e2);
    cs_release();
    checks++; if (r1 !== 8'hFF) begin failures++; $display("FAIL coinc_first got %h required ff", r1); end
    checks++; if (r2 !== v)     begin failures++; $display("FAIL coinc_second got %h required %h", r2, v); end
    wb_read(1'b0, d); m_rx_unread = 1'b0;
    wb_write(1'b1, 4'b0001, 32'h8); m_overrun = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r, e, b;
    logic [31:0] d;
    set_mode(2'd1);
    write_tx(8'h99);
    cs_assert();
    xfer(8'($urandom), r, e);
    write_tx(8'h42);
    spi_bits(8'($urandom), 4, r);
    @(negedge clk_i); rst_i = 1'b0;
    tick(2);
    checks++; if (irq !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b1 || ack !== 1'b0 || dat_o !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs got irq=%b oe=%b miso=%b ack=%b dat=%h required 0 0 1 0 0", irq, miso_oe, miso, ack, dat_o);
    end
    cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(2);
    rst_i = 1'b1;
    m_conf = '0; m_tx_buf = '0; m_tx_full = 1'b0; m_rx_byte = '0; m_rx_unread = 1'b0; m_overrun = 1'b0;
    tick(4);
    wb_read(1'b1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_status got %h required 0", d); end
    wb_read(1'b0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rstmid_data got %h required 0", d); end
    b = 8'($urandom);
    cs_assert();
    xfer(b, r, e);
    cs_release();
    checks++; if (r !== 8'hFF) begin failures++; $display("FAIL rstmid_miso got %h required ff", r); end
    wb_read(1'b0, d); m_rx_unread = 1'b0;
    checks++; if (d !== {24'h0, b}) begin failures++; $display("FAIL rstmid_rx got %h required %h", d, b); end
  endtask

  task automatic test_random();
    logic [7:0] r, e, b;
    logic [31:0] d;
    int n;
    for (int s = 0; s < 4; s++) begin
      set_mode(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
      cs_assert();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        xfer(b, r, e);
        checks++; if (r !== e) begin failures++; $display("FAIL rand_miso s%0d b%0d got %h required %h", s, k, r, e); end
        if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
        if ($urandom_range(0, 2) == 0) begin
          wb_read(1'b0, d);
          checks++; if (d !== {24'h0, m_rx_byte}) begin failures++; $display("FAIL rand_rx_mid got %h required %h", d, m_rx_byte); end
          m_rx_unread = 1'b0;
        end
      end
      cs_release();
      wb_read(1'b1, d);
      checks++; if (d !== m_status(1'b0)) begin failures++; $display("FAIL rand_status s%0d got %h required %h", s, d, m_status(1'b0)); end
      wb_read(1'b0, d);
      checks++; if (d !== {24'h0, m_rx_byte}) begin failures++; $display("FAIL rand_rx got %h required %h", d, m_rx_byte); end
      m_rx_unread = 1'b0;
      wb_write(1'b1, 4'b0001, 32'h8); m_overrun = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_overrun();
    test_partial();
    test_coincident_write();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: IDLE_BYTE, 8'hFF, byte shifted out when no transmit byte is queued.
REQ-002 clk_i  input  1  system clock; all logic in this domain.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 sclk  input  1  SPI clock from external master, asynchronous to clk_i.
REQ-005 cs_n  input  1  SPI chip select from master, active-low, asynchronous.
REQ-006 mosi  input  1  serial data from master, asynchronous.
REQ-007 miso  output  1  serial data to master.
REQ-008 miso_oe  output  1  miso output enable, high while selected.
REQ-009 irq  output  1  level interrupt = rx_unread | overrun.
REQ-010 bus  if_wb.slave  --  Wishbone slave: cyc, stb, we, adr, sel, dat (32-bit), ack, stall.

Function
REQ-011 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer before use; sclk edges detected from the synchronized value; supported sclk <= clk_i/8.
REQ-012 conf[1] = cpol, conf[0] = cpha; leading edge = sclk leaving its cpol idle level; trailing edge = return to it.
REQ-013 Sample edge: leading if cpha=0, trailing if cpha=1; each sample shifts synchronized mosi into rx_shift LSB, MSB-first, and increments the 3-bit bit counter.
REQ-014 miso SHALL always equal tx_shift[7]; miso_oe = synchronized ~cs_n.
REQ-015 cs_n falling edge: bit counter := 0, rx_shift := 0, tx_shift := tx_buf if tx_full else IDLE_BYTE, tx_full := 0.
REQ-016 Shift edge: cpha=0 trailing edges; cpha=1 leading edges except the first leading edge of each byte; each shift edge shifts tx_shift left by one.
REQ-017 Byte boundary (cpha=0: 8th trailing edge; cpha=1: 8th sample edge): rx_byte := completed rx_shift; overrun := 1 if rx_unread already set; rx_unread := 1; tx_shift reloaded per REQ-015 rule instead of shifting; bit counter := 0.
REQ-018 cs_n rising mid-byte: partial byte discarded, rx_byte/rx_unread unchanged, bit counter := 0; edges while cs_n high ignored.
REQ-019 Bus FSM states S_IDLE, S_DONE; S_IDLE with cyc & stb -> register action, -> S_DONE; S_DONE -> S_IDLE; ack = (state == S_DONE), i.e. one-cycle latency; stall = 0.
REQ-020 adr[2]=0 write: tx_buf := dat_i[7:0], tx_full := 1; write while tx_full overwrites silently.
REQ-021 adr[2]=0 read: dat_o := {24'h0, rx_byte}, rx_unread := 0.
REQ-022 adr[2]=1 write: sel[2] loads conf := dat_i[23:16]; sel[0] with dat_i[3]=1 clears overrun; conf changes take effect immediately (software changes it only while deselected).
REQ-023 adr[2]=1 read: dat_o := {8'h0, conf, 11'h0, cs_active, overrun, tx_full, 1'b0, rx_unread}.
REQ-024 Simultaneous byte boundary and data read: read returns the old rx_byte; rx_unread stays 1; overrun unchanged by the read.
REQ-025 Simultaneous reload (REQ-015/017) and data write: reload uses tx_buf/tx_full state from before the write; the write then sets tx_buf and tx_full := 1.
REQ-026 Simultaneous boundary and overrun-clear write: overrun set wins.
REQ-027 dat_o SHALL hold its last value outside read cycles.

Reset
REQ-028 While rst_i low: state S_IDLE, conf 8'h00, tx_buf 8'h00, tx_full 0, rx_byte 8'h00, rx_unread 0, overrun 0, dat_o 0, bit counter 0, tx_shift IDLE_BYTE, synchronizers high (cs_n inactive), miso_oe 0, irq 0, ack 0.
REQ-029 Reset asserted mid-transfer aborts it; after release, transfers begin only at the next cs_n falling edge.

Verification
REQ-030 Mode 0, write 8'hA5 to data reg, master sends 8'h3C -> master receives 8'hA5; data read returns 8'h3C; rx_unread and irq go 1, then rx_unread 0 after the read.
REQ-031 Modes 1, 2, 3 each: tx 8'h5A, master sends 8'hC3 -> bytes exchanged correctly in all modes.
REQ-032 Nothing queued, master sends 2 bytes 8'h01, 8'h02 without reads -> master receives 8'hFF twice; rx_byte = 8'h02; overrun = 1; status write dat[3]=1, sel[0] -> overrun 0.
REQ-033 cs_n deasserted after 4 bits, then full byte 8'h77 -> partial byte discarded; rx_byte = 8'h77; overrun 0.
REQ-034 Data write coincident with the cs_n-fall reload, tx_full 0 -> first byte out is 8'hFF, tx_full = 1 afterwards, next byte out is the written value.
REQ-035 rst_i pulsed low mid-byte -> all REQ-028 values observed; next complete transfer succeeds.
